// File: rtl/uart_tx_fifo_if.sv
// UART transmitter bus: write side (wr_en/wr_data/parity_odd),
// line timing (baud_tick) and status/line outputs.
// master = the system driving writes, slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) ();
    logic                            baud_tick;
    logic                            wr_en;
    logic [DATA_BITS-1:0]            wr_data;
    logic                            parity_odd;
    logic                            TxD;
    logic                            TBR;
    logic                            busy;
    logic [$clog2(FIFO_DEPTH):0]     fifo_count;
    logic                            overflow;

    modport master (
        output baud_tick, wr_en, wr_data, parity_odd,
        input  TxD, TBR, busy, fifo_count, overflow
    );

    modport slave (
        input  baud_tick, wr_en, wr_data, parity_odd,
        output TxD, TBR, busy, fifo_count, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits. The line only advances on baud_tick.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit
// (parity_odd chooses odd/even, captured when the character is popped).
//
// state  | meaning
// IDLE   | line high, waiting for a tick with data queued
// START  | start bit (low) on the line
// DATA   | shifting data bits out, LSB first
// PARITY | parity bit on the line (only with UART_TX_PARITY_EN)
// STOP   | stop bit(s) high; pops back-to-back if more data queued
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 txd_q, txd_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 pop, push;
    logic [DATA_BITS-1:0] head;

    assign head = mem_q[rptr_q];

    // Next-state for the line FSM and FIFO bookkeeping.
    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.baud_tick && count_q != '0) pop = 1'b1;
            end
            S_START: begin
                if (bus.baud_tick) begin
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bus.baud_tick) begin
                    if (bit_cnt_q < LAST_BIT) begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = parity_q;
                        state_d = S_PARITY;
`else
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bus.baud_tick) begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (bus.baud_tick) begin
                    if (STOP_BITS == 2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pop always loads the shifter and drives the start bit.
        if (pop) begin
            shift_d = head;
            txd_d   = 1'b0;
            state_d = S_START;
`ifdef UART_TX_PARITY_EN
            parity_d = (^head) ^ bus.parity_odd;
`endif
        end

        push    = bus.wr_en && (count_q != DEPTH_C || pop);
        wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    // State and control registers; reset aborts any frame and empties the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            txd_q      <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wptr_q] <= bus.wr_data;
    end

    assign bus.TxD        = txd_q;
    assign bus.TBR        = (count_q != DEPTH_C);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.fifo_count = count_q;
    assign bus.overflow   = bus.wr_en && !push && !reset;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at default parameters.
module tb_uart_tx_fifo;
    localparam int DB = 8;
    localparam int SB = 1;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic reset;
    logic tick_en;
    int   div;
    int   n_checks = 0;
    int   n_err    = 0;
    logic [DB-1:0] tx_q[$];

    uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) bus ();

    uart_tx_fifo #(.DATA_BITS(DB), .STOP_BITS(SB), .FIFO_DEPTH(FD)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        div = 0;
        bus.baud_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.baud_tick = tick_en && (div == 15);
            div = (div == 15) ? 0 : div + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [DB-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        step(1);
        bus.wr_en   = 1'b0;
    endtask

    // Expected line bits for every queued character, sampled mid-bit.
    task automatic expect_stream(input logic odd);
        logic e[$];
        int   n, flen;
        bit   found;
        n = tx_q.size();
        foreach (tx_q[k]) begin
            e.push_back(1'b0);
            for (int i = 0; i < DB; i++) e.push_back(tx_q[k][i]);
`ifdef UART_TX_PARITY_EN
            e.push_back((^tx_q[k]) ^ odd);
`endif
            for (int s = 0; s < SB; s++) e.push_back(1'b1);
        end
        flen  = e.size() / n;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            step(1);
            if (bus.TxD == 1'b0) found = 1'b1;
        end
        chk("start_seen", 32'(found), 32'd1);
        if (found) begin
            step(8);
            for (int i = 0; i < e.size(); i++) begin
                if (i % flen == 0)
                    chk($sformatf("count_at_frame%0d", i / flen),
                        32'(bus.fifo_count), 32'(n - 1 - i / flen));
                chk($sformatf("txd_bit%0d", i), 32'(bus.TxD), 32'(e[i]));
                step(16);
            end
            chk("busy_after", 32'(bus.busy), 32'd0);
            chk("idle_txd", 32'(bus.TxD), 32'd1);
        end
        tx_q.delete();
    endtask

    initial begin
        int   lows;
        bit   seen;
        reset          = 1'b1;
        tick_en        = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_data    = '0;
        bus.parity_odd = 1'b0;
        step(3);
        chk("rst_txd", 32'(bus.TxD), 32'd1);
        chk("rst_tbr", 32'(bus.TBR), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_count", 32'(bus.fifo_count), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        reset = 1'b0;
        step(1);

        // Single frame 0xA5: 0,1,0,1,0,0,1,0,1,(parity),1
        tick_en = 1'b1;
        push(8'hA5);
        tx_q.push_back(8'hA5);
        expect_stream(1'b0);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: even parity bit 1, odd parity bit 0
        bus.parity_odd = 1'b0;
        push(8'h07);
        tx_q.push_back(8'h07);
        expect_stream(1'b0);
        bus.parity_odd = 1'b1;
        push(8'h07);
        tx_q.push_back(8'h07);
        expect_stream(1'b1);
        bus.parity_odd = 1'b0;
`else
        // parity_odd must not change the frame
        bus.parity_odd = 1'b1;
        push(8'h07);
        tx_q.push_back(8'h07);
        expect_stream(1'b0);
        bus.parity_odd = 1'b0;
`endif

        // Three back-to-back frames
        tick_en = 1'b0;
        step(1);
        push(8'h11);
        push(8'h22);
        push(8'h33);
        chk("b2b_count3", 32'(bus.fifo_count), 32'd3);
        tx_q = '{8'h11, 8'h22, 8'h33};
        tick_en = 1'b1;
        expect_stream(1'b0);

        // Fill while stalled, then overflow
        tick_en = 1'b0;
        step(1);
        push(8'hC3);
        push(8'h18);
        push(8'hE7);
        chk("tbr_before_full", 32'(bus.TBR), 32'd1);
        push(8'h5A);
        chk("tbr_full", 32'(bus.TBR), 32'd0);
        chk("count_full", 32'(bus.fifo_count), 32'd4);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h99;
        #1;
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        step(1);
        bus.wr_en = 1'b0;
        #1;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);
        chk("count_after_ovf", 32'(bus.fifo_count), 32'd4);
        tx_q = '{8'hC3, 8'h18, 8'hE7, 8'h5A};
        tick_en = 1'b1;
        expect_stream(1'b0);

        // Full FIFO, write in the same cycle as a pop
        tick_en = 1'b0;
        step(1);
        push(8'h0F);
        push(8'hF0);
        push(8'h81);
        push(8'h7E);
        tick_en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step(1);
            if (bus.baud_tick) seen = 1'b1;
        end
        chk("tick_seen", 32'(seen), 32'd1);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h3D;
        #1;
        chk("popwr_no_ovf", 32'(bus.overflow), 32'd0);
        step(1);
        bus.wr_en = 1'b0;
        chk("popwr_count", 32'(bus.fifo_count), 32'd4);
        chk("popwr_tbr", 32'(bus.TBR), 32'd0);
        tx_q = '{8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h3D};
        expect_stream(1'b0);

        // Reset mid-DATA with two entries queued
        tick_en = 1'b0;
        step(1);
        push(8'h3C);
        push(8'h01);
        push(8'h02);
        tick_en = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            step(1);
            if (bus.TxD == 1'b0) seen = 1'b1;
        end
        chk("abort_start_seen", 32'(seen), 32'd1);
        step(48);
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        chk("abort_count_pre", 32'(bus.fifo_count), 32'd2);
        reset       = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hAA;
        step(1);
        chk("abort_txd", 32'(bus.TxD), 32'd1);
        chk("abort_count", 32'(bus.fifo_count), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_tbr", 32'(bus.TBR), 32'd1);
        chk("abort_ovf", 32'(bus.overflow), 32'd0);
        reset     = 1'b0;
        bus.wr_en = 1'b0;
        lows = 0;
        for (int c = 0; c < 400; c++) begin
            step(1);
            if (bus.TxD !== 1'b1 || bus.busy !== 1'b0) lows++;
        end
        chk("no_tx_after_abort", 32'(lows), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
